// File: rtl/bus_req_responder.sv
// Request/acknowledge responder: captures a payload, hands it downstream, then acks after a minimum latency.
// Optional protocol checker enabled by defining BUS_REQ_RESPONDER_PROTO_CHK_EN.
//
// state | meaning
// IDLE  | no transaction outstanding
// WAIT  | payload captured; waiting for latency expiry and downstream handoff
// ACK   | single-cycle bus_ack; a new request may be accepted here
module bus_req_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  bus_req,
  input  logic [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_ack,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       done;
  logic       capture;
  logic       handoff;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    handoff   = 1'b0;
    case (state)
      IDLE: begin
        if (bus_req) begin
          capture   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        handoff = out_valid & out_ready;
        // terminal count alone is not enough: the payload must also have left
        if ((cnt == 4'd0) && (done || handoff)) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (bus_req) begin
          capture   = 1'b1;
          state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      bus_ack   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cnt       <= 4'd0;
      done      <= 1'b0;
    end else begin
      bus_ack <= (state_nxt == ACK);
      if (capture) begin
        out_data  <= bus_data;
        out_valid <= 1'b1;
        cnt       <= CNT_LOAD;
        done      <= 1'b0;
      end else if (state == WAIT) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end
        if (handoff) begin
          out_valid <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef BUS_REQ_RESPONDER_PROTO_CHK_EN
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      proto_err <= 1'b0;
    end else if ((state == WAIT) && bus_req) begin
      proto_err <= 1'b1;
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_req_responder.sv
// Bench for bus_req_responder: two instances (LATENCY 2 and 1) driven by shared stimulus,
// checked every cycle against a transaction-level model (ack edge = max(accept+LATENCY, handoff)).
module tb_bus_req_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;
`ifdef BUS_REQ_RESPONDER_PROTO_CHK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic        clk;
  logic        reset_l;
  logic        bus_req;
  logic [31:0] bus_data;
  logic        out_ready;
  logic [1:0]  ack_w;
  logic [1:0]  valid_w;
  logic [1:0]  busy_w;
  logic [1:0]  perr_w;
  logic [31:0] data0_w;
  logic [31:0] data1_w;

  int n_tests = 0;
  int n_fail  = 0;

  // transaction-level model state, one slot per instance
  int          edge_n;
  logic        m_pend  [2];
  int          m_acc   [2];
  int          m_ho    [2];
  logic        m_valid [2];
  logic [31:0] m_data  [2];
  logic        m_ack   [2];
  logic        m_perr  [2];
  logic        prev_ack[2];

  bus_req_responder #(.DATA_WIDTH(32), .LATENCY(LAT0)) dut0 (
    .clk(clk), .reset_l(reset_l), .bus_req(bus_req), .bus_data(bus_data),
    .bus_ack(ack_w[0]), .out_valid(valid_w[0]), .out_data(data0_w),
    .out_ready(out_ready), .busy(busy_w[0]), .proto_err(perr_w[0])
  );

  bus_req_responder #(.DATA_WIDTH(32), .LATENCY(LAT1)) dut1 (
    .clk(clk), .reset_l(reset_l), .bus_req(bus_req), .bus_data(bus_data),
    .bus_ack(ack_w[1]), .out_valid(valid_w[1]), .out_data(data1_w),
    .out_ready(out_ready), .busy(busy_w[1]), .proto_err(perr_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i]   = 1'b0;
      m_acc[i]    = 0;
      m_ho[i]     = -1;
      m_valid[i]  = 1'b0;
      m_data[i]   = 32'h0;
      m_ack[i]    = 1'b0;
      m_perr[i]   = 1'b0;
      prev_ack[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    edge_n++;
    if (!reset_l) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_ack[i] = 1'b0;
        if (m_pend[i]) begin
          if (m_valid[i] && out_ready) begin
            m_valid[i] = 1'b0;
            m_ho[i]    = edge_n;
          end
          if ((m_ho[i] >= 0) && ((edge_n - m_acc[i]) >= lat(i))) begin
            m_ack[i]  = 1'b1;
            m_pend[i] = 1'b0;
          end
          if (bus_req && PCHK) m_perr[i] = 1'b1;
        end else if (bus_req) begin
          m_pend[i]  = 1'b1;
          m_acc[i]   = edge_n;
          m_ho[i]    = -1;
          m_valid[i] = 1'b1;
          m_data[i]  = bus_data;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] d;
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? data0_w : data1_w;
      chk($sformatf("ack[L%0d]", lat(i)), 32'(ack_w[i]), 32'(m_ack[i]));
      chk($sformatf("valid[L%0d]", lat(i)), 32'(valid_w[i]), 32'(m_valid[i]));
      chk($sformatf("data[L%0d]", lat(i)), d, m_data[i]);
      chk($sformatf("busy[L%0d]", lat(i)), 32'(busy_w[i]), 32'(m_pend[i] | m_ack[i]));
      chk($sformatf("perr[L%0d]", lat(i)), 32'(perr_w[i]), 32'(m_perr[i]));
      chk($sformatf("ack_pulse[L%0d]", lat(i)), 32'(ack_w[i] & prev_ack[i]), 32'd0);
      prev_ack[i] = ack_w[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic req(input logic [31:0] d);
    bus_req  = 1'b1;
    bus_data = d;
    step();
    bus_req  = 1'b0;
  endtask

  task automatic reset_pulse();
    #2 reset_l = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 reset_l = 1'b1;
  endtask

  initial begin
    reset_l   = 1'b1;
    bus_req   = 1'b0;
    bus_data  = 32'h0;
    out_ready = 1'b1;
    edge_n    = 0;
    model_reset();

    // reset state
    #1 reset_l = 1'b0;
    #1;
    check_all();
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    step();
    #3 reset_l = 1'b1;

    // basic transaction, LATENCY=2 timing
    step();
    step();
    req(32'hfeed);
    chk("s30_valid", 32'(valid_w[0]), 32'd1);
    step();
    chk("s30_handoff", 32'(valid_w[0]), 32'd0);
    chk("s30_noack", 32'(ack_w[0]), 32'd0);
    step();
    chk("s30_ack", 32'(ack_w[0]), 32'd1);
    step();
    chk("s30_ack_end", 32'(ack_w[0]), 32'd0);
    chk("s30_idle", 32'(busy_w[0]), 32'd0);

    // stalled downstream, LATENCY=1
    out_ready = 1'b0;
    req(32'hfeed);
    repeat (5) begin
      step();
      chk("s31_hold", data1_w, 32'hfeed);
      chk("s31_valid", 32'(valid_w[1]), 32'd1);
      chk("s31_noack", 32'(ack_w[1]), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("s31_ack", 32'(ack_w[1]), 32'd1);
    step();
    chk("s31_single", 32'(ack_w[1]), 32'd0);

    // back-to-back request during ACK
    req(32'hfeed);
    step();
    step();
    chk("s32_ack1", 32'(ack_w[0]), 32'd1);
    req(32'h1234);
    chk("s32_width", 32'(ack_w[0]), 32'd0);
    chk("s32_data", data0_w, 32'h1234);
    step();
    chk("s32_wait", 32'(ack_w[0]), 32'd0);
    step();
    chk("s32_ack2", 32'(ack_w[0]), 32'd1);
    step();

    // request during WAIT is ignored (and flagged when the checker is built in)
    req(32'hfeed);
    req(32'hdead);
    chk("s33_perr", 32'(perr_w[0]), 32'(PCHK));
    chk("s33_data", data0_w, 32'hfeed);
    step();
    chk("s33_ack", 32'(ack_w[0]), 32'd1);
    step();
    step();
    chk("s33_sticky", 32'(perr_w[0]), 32'(PCHK));

    // reset pulsed while in WAIT
    out_ready = 1'b0;
    req(32'hfeed);
    step();
    reset_pulse();
    chk("s34_valid", 32'(valid_w[0]), 32'd0);
    chk("s34_data", data0_w, 32'h0);
    chk("s34_busy", 32'(busy_w[0]), 32'd0);
    chk("s34_perr", 32'(perr_w[0]), 32'd0);
    out_ready = 1'b1;
    req(32'hbeef);
    chk("s34_accept", data0_w, 32'hbeef);
    step();
    chk("s34_noack", 32'(ack_w[0]), 32'd0);
    step();
    chk("s34_ack", 32'(ack_w[0]), 32'd1);
    step();

    // randomized traffic with occasional asynchronous resets
    repeat (600) begin
      bus_req   = !bus_req && ($urandom_range(0, 2) == 0);
      bus_data  = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) reset_pulse();
      step();
    end
    bus_req = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
